// File: rtl/vmcoffee_pkg.sv
// rtl/vmcoffee_pkg.sv - shared states, default capacities and helpers for the vmcoffee brew unit
package vmcoffee_pkg;

    localparam int DEF_GRIND_CYCLES  = 3;
    localparam int DEF_HEAT_CYCLES   = 4;
    localparam int DEF_POUR_CYCLES   = 5;
    localparam int DEF_WATER_PER_CUP = 2;
    localparam int DEF_WATER_MAX     = 30;
    localparam int DEF_BEAN_DOSES    = 8;

    localparam int WATER_W = 5;
    localparam int BEAN_W  = 4;
    localparam int PHASE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRIND  = 3'd1,
        ST_HEAT   = 3'd2,
        ST_POUR   = 3'd3,
        ST_FINISH = 3'd4
    } brew_state_t;

    // Reservoir level after one cup; clamps at empty instead of wrapping.
    function automatic logic [WATER_W-1:0] water_after_cup(input logic [WATER_W-1:0] level,
                                                           input logic [WATER_W-1:0] dose);
        return (level >= dose) ? level - dose : '0;
    endfunction

endpackage

// File: rtl/vmcoffee_brewer_if.sv
// rtl/vmcoffee_brewer_if.sv - request/refill inputs and status/drive outputs of the brew unit
interface vmcoffee_brewer_if;
    import vmcoffee_pkg::*;

    logic               COFFEE;
    logic               REFILL_W;
    logic               REFILL_B;
    logic [WATER_W-1:0] WATER;
    logic               BEANS;
    logic               BUSY;
    logic               GRINDER;
    logic               HEATER;
    logic               PUMP;
    logic               DONE;
    logic               DROPPED;

    modport master (
        output COFFEE, REFILL_W, REFILL_B,
        input  WATER, BEANS, BUSY, GRINDER, HEATER, PUMP, DONE, DROPPED
    );

    modport slave (
        input  COFFEE, REFILL_W, REFILL_B,
        output WATER, BEANS, BUSY, GRINDER, HEATER, PUMP, DONE, DROPPED
    );

endinterface

// File: rtl/vmcoffee_phase_timer.sv
// rtl/vmcoffee_phase_timer.sv - loadable 4-bit down-counter timing each brew phase
module vmcoffee_phase_timer
    import vmcoffee_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_load,
    input  logic [PHASE_W-1:0] i_value,
    output logic               o_expired
);

    logic [PHASE_W-1:0] r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/vmcoffee_brewer.sv
// rtl/vmcoffee_brewer.sv - grind/heat/pour sequencer owning the reservoir and hopper models
module vmcoffee_brewer
    import vmcoffee_pkg::*;
#(
    parameter int GRIND_CYCLES  = DEF_GRIND_CYCLES,
    parameter int HEAT_CYCLES   = DEF_HEAT_CYCLES,
    parameter int POUR_CYCLES   = DEF_POUR_CYCLES,
    parameter int WATER_PER_CUP = DEF_WATER_PER_CUP,
    parameter int WATER_MAX     = DEF_WATER_MAX,
    parameter int BEAN_DOSES    = DEF_BEAN_DOSES
) (
    input  logic                clk,
    input  logic                rstn,
    vmcoffee_brewer_if.slave    io_bus
);

    // Timer holds cycles-1 so a phase lasts exactly its parameter count.
    localparam logic [PHASE_W-1:0] GRIND_LOAD = PHASE_W'(GRIND_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HEAT_LOAD  = PHASE_W'(HEAT_CYCLES - 1);
    localparam logic [PHASE_W-1:0] POUR_LOAD  = PHASE_W'(POUR_CYCLES - 1);
    localparam logic [WATER_W-1:0] CUP_DOSE   = WATER_W'(WATER_PER_CUP);
    localparam logic [WATER_W-1:0] FULL_WATER = WATER_W'(WATER_MAX);
    localparam logic [BEAN_W-1:0]  FULL_BEANS = BEAN_W'(BEAN_DOSES);

    brew_state_t        r_state;
    brew_state_t        w_next_state;
    logic               r_coffee_q;
    logic               r_dropped;
    logic [WATER_W-1:0] r_water;
    logic [BEAN_W-1:0]  r_beans;

    logic               w_req;
    logic               w_can_brew;
    logic               w_load;
    logic [PHASE_W-1:0] w_load_value;
    logic               w_expired;

    assign w_req      = io_bus.COFFEE & ~r_coffee_q;
    assign w_can_brew = (r_water >= CUP_DOSE) && (r_beans != '0);

    vmcoffee_phase_timer u_phase_timer (
        .clk       (clk),
        .rstn      (rstn),
        .i_load    (w_load),
        .i_value   (w_load_value),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_value = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_req && w_can_brew) begin
                    w_next_state = ST_GRIND;
                    w_load       = 1'b1;
                    w_load_value = GRIND_LOAD;
                end
            end
            ST_GRIND: begin
                if (w_expired) begin
                    w_next_state = ST_HEAT;
                    w_load       = 1'b1;
                    w_load_value = HEAT_LOAD;
                end
            end
            ST_HEAT: begin
                if (w_expired) begin
                    w_next_state = ST_POUR;
                    w_load       = 1'b1;
                    w_load_value = POUR_LOAD;
                end
            end
            ST_POUR: begin
                if (w_expired) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Eligibility reads the stored levels, so a same-cycle refill cannot rescue a request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_coffee_q <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_coffee_q <= io_bus.COFFEE;
            r_dropped  <= w_req & ((r_state != ST_IDLE) | ~w_can_brew);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_water <= FULL_WATER;
            r_beans <= FULL_BEANS;
        end else begin
            if (r_state == ST_IDLE) begin
                if (io_bus.REFILL_W) r_water <= FULL_WATER;
                if (io_bus.REFILL_B) r_beans <= FULL_BEANS;
            end
            if (r_state == ST_GRIND && w_expired) begin
                r_beans <= r_beans - 1'b1;
            end
            if (r_state == ST_POUR && w_expired) begin
                r_water <= water_after_cup(r_water, CUP_DOSE);
            end
        end
    end

    assign io_bus.WATER   = r_water;
    assign io_bus.BEANS   = (r_beans != '0);
    assign io_bus.BUSY    = (r_state != ST_IDLE);
    assign io_bus.GRINDER = (r_state == ST_GRIND);
    assign io_bus.HEATER  = (r_state == ST_HEAT);
    assign io_bus.PUMP    = (r_state == ST_POUR);
    assign io_bus.DONE    = (r_state == ST_FINISH);
    assign io_bus.DROPPED = r_dropped;

endmodule

// File: tb/tb_vmcoffee_brewer.sv
// tb/tb_vmcoffee_brewer.sv - directed bench for vmcoffee_brewer with a DONE/DROPPED scoreboard
module tb_vmcoffee_brewer;

    localparam int G        = 3;
    localparam int H        = 4;
    localparam int P        = 5;
    localparam int WPC      = 2;
    localparam int WMAX     = 30;
    localparam int BMAX     = 8;
    localparam int CUP_SPAN = G + H + P + 1;

    typedef struct {
        int         cyc;
        logic [4:0] water;
        logic       beans;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   water_m = WMAX;
    int   beans_m = BMAX;
    exp_t done_q[$];
    exp_t drop_q[$];

    vmcoffee_brewer_if bus ();

    vmcoffee_brewer dut (
        .clk    (clk),
        .rstn   (rstn),
        .io_bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every DONE/DROPPED pulse must match the oldest outstanding expectation of its kind.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && bus.DONE) begin
            check("done_expected", 32'(done_q.size() != 0), 1);
            if (done_q.size() != 0) begin
                e = done_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_water", 32'(bus.WATER), 32'(e.water));
                check("done_beans", 32'(bus.BEANS), 32'(e.beans));
            end
        end
        if (rstn && bus.DROPPED) begin
            check("drop_expected", 32'(drop_q.size() != 0), 1);
            if (drop_q.size() != 0) begin
                e = drop_q.pop_front();
                check("drop_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send_req(input bit busy);
        exp_t e;
        e.water = 5'(water_m);
        e.beans = (beans_m != 0);
        if (busy || water_m < WPC || beans_m == 0) begin
            e.cyc = cyc + 1;
            drop_q.push_back(e);
        end else begin
            water_m = (water_m >= WPC) ? water_m - WPC : 0;
            beans_m = beans_m - 1;
            e.cyc   = cyc + CUP_SPAN;
            e.water = 5'(water_m);
            e.beans = (beans_m != 0);
            done_q.push_back(e);
        end
        bus.COFFEE = 1'b1;
        tick();
        bus.COFFEE = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.BUSY || done_q.size() != 0 || drop_q.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n < 40), 1);
        tick();
    endtask

    task automatic wait_for(input int which);
        int n = 0;
        while (n < 30 && !((which == 0) ? bus.HEATER : bus.PUMP)) begin
            tick();
            n++;
        end
        check((which == 0) ? "wait_heater" : "wait_pump", 32'(n < 30), 1);
    endtask

    task automatic refill(input bit w, input bit b);
        bus.REFILL_W = w;
        bus.REFILL_B = b;
        tick();
        bus.REFILL_W = 1'b0;
        bus.REFILL_B = 1'b0;
        if (w) water_m = WMAX;
        if (b) beans_m = BMAX;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.COFFEE   = 1'b0;
        bus.REFILL_W = 1'b0;
        bus.REFILL_B = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_water", 32'(bus.WATER), WMAX);
        check("rst_beans", 32'(bus.BEANS), 1);
        check("rst_outs", {26'd0, bus.BUSY, bus.GRINDER, bus.HEATER, bus.PUMP, bus.DONE, bus.DROPPED}, 0);
        rstn = 1'b1;
        tick();

        // First cup: phase-by-phase drive pattern after the accepting edge.
        send_req(1'b0);
        for (int j = 0; j < CUP_SPAN; j++) begin
            check("grinder", 32'(bus.GRINDER), 32'(j < G));
            check("heater",  32'(bus.HEATER),  32'(j >= G && j < G + H));
            check("pump",    32'(bus.PUMP),    32'(j >= G + H && j < G + H + P));
            check("done",    32'(bus.DONE),    32'(j == G + H + P));
            check("busy",    32'(bus.BUSY),    1);
            tick();
        end
        check("cup1_idle", 32'(bus.BUSY), 0);
        check("cup1_water", 32'(bus.WATER), 28);
        wait_idle();

        // Second edge during HEAT is dropped; the running cup is unaffected.
        send_req(1'b0);
        wait_for(0);
        send_req(1'b1);
        wait_idle();
        check("cup2_water", 32'(bus.WATER), 26);

        // Refill in IDLE, then reset in the middle of POUR.
        refill(1'b1, 1'b0);
        check("refill_w", 32'(bus.WATER), WMAX);
        bus.COFFEE = 1'b1;
        tick();
        bus.COFFEE = 1'b0;
        wait_for(1);
        rstn = 1'b0;
        #1;
        check("rst_mid_pump", 32'(bus.PUMP), 0);
        check("rst_mid_busy", 32'(bus.BUSY), 0);
        check("rst_mid_water", 32'(bus.WATER), WMAX);
        check("rst_mid_done", 32'(bus.DONE), 0);
        rstn = 1'b1;
        water_m = WMAX;
        beans_m = BMAX;
        repeat (16) tick();
        check("rst_mid_water_after", 32'(bus.WATER), WMAX);

        // Nine cups from a full hopper: the ninth is dropped.
        for (int c = 0; c < 9; c++) begin
            send_req(1'b0);
            wait_idle();
        end
        check("hopper_empty", 32'(bus.BEANS), 0);
        refill(1'b0, 1'b1);
        check("refill_b", 32'(bus.BEANS), 1);
        send_req(1'b0);
        wait_idle();

        // Fifteen cups drain the reservoir; refill beans as the hopper runs dry.
        refill(1'b1, 1'b0);
        for (int c = 0; c < 15; c++) begin
            if (beans_m == 0) refill(1'b0, 1'b1);
            send_req(1'b0);
            wait_idle();
        end
        check("water_empty", 32'(bus.WATER), 0);
        refill(1'b0, 1'b1);

        // Sixteenth request with a same-cycle water refill is judged on the old level.
        bus.REFILL_W = 1'b1;
        send_req(1'b0);
        bus.REFILL_W = 1'b0;
        water_m = WMAX;
        wait_idle();
        check("water_refilled", 32'(bus.WATER), WMAX);

        // REFILL_W during POUR is ignored.
        send_req(1'b0);
        wait_for(1);
        bus.REFILL_W = 1'b1;
        tick();
        tick();
        bus.REFILL_W = 1'b0;
        wait_idle();
        check("pour_refill_ignored", 32'(bus.WATER), 32'(water_m));

        check("queues_drained", 32'(done_q.size() + drop_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vmcoffee_brewer.md
# vmcoffee_brewer

Brew-unit responder for the `vmcoffee` vending controller. It consumes the controller's `COFFEE` dispense request and runs a fixed grind → heat → pour sequence that drives the grinder, heater and pump. It owns the water-reservoir and bean-hopper models and drives the `WATER` level and `BEANS` presence signals back into `vmcoffee`, closing the loop.

## Interface
Parameters:
- `GRIND_CYCLES`, default 3: grinder-on cycles per cup, legal range 1–15.
- `HEAT_CYCLES`, default 4: heater-on cycles per cup, legal range 1–15.
- `POUR_CYCLES`, default 5: pump-on cycles per cup, legal range 1–15.
- `WATER_PER_CUP`, default 2: water units consumed per cup.
- `WATER_MAX`, default 30: full-reservoir level, ≤ 31.
- `BEAN_DOSES`, default 8: doses in a full hopper, ≤ 15.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rstn`, input, 1: reset, asynchronous, active-low.
- `COFFEE`, input, 1: dispense request from `vmcoffee`; the rising edge is the trigger.
- `REFILL_W`, input, 1: reservoir refilled, level-sampled.
- `REFILL_B`, input, 1: hopper refilled, level-sampled.
- `WATER`, output, 5: current reservoir level.
- `BEANS`, output, 1: high when the hopper holds at least one dose.
- `BUSY`, output, 1: high in any state other than IDLE.
- `GRINDER`, output, 1: grinder drive.
- `HEATER`, output, 1: heater drive.
- `PUMP`, output, 1: pump drive.
- `DONE`, output, 1: one-cycle pulse when a cup completes.
- `DROPPED`, output, 1: one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, GRIND, HEAT, POUR, FINISH.
- Edge detect:
  - `coffee_q` is a register of `COFFEE`, reset value 0.
  - A request is `COFFEE & ~coffee_q`.
  - `COFFEE` already high when reset releases counts as a request.
- IDLE, on a request:
  - If `WATER >= WATER_PER_CUP` and the bean count is nonzero: go to GRIND.
  - Otherwise: pulse `DROPPED` for one cycle and stay in IDLE.
  - The check uses the register values from before any same-cycle refill.
- Requests while `BUSY` are rejected: `DROPPED` pulses, and the current cup is unaffected.
- GRIND/HEAT/POUR:
  - Each state lasts exactly its parameter's cycle count.
  - `GRINDER`, `HEATER` and `PUMP` are each high exactly while in their own state; never two at once.
- Bean count decrements by 1 on the GRIND→HEAT transition.
- Water level:
  - Decrements by `WATER_PER_CUP` on the POUR→FINISH transition.
  - Saturates at 0; the 5-bit value never wraps.
- FINISH: one cycle, `DONE`=1, then IDLE.
- Refills:
  - Honoured only in IDLE and ignored otherwise.
  - `REFILL_W` loads `WATER_MAX`; `REFILL_B` loads `BEAN_DOSES`.
  - Both may apply in the same cycle.
- Reset values:
  - State IDLE; `WATER`=`WATER_MAX`; bean count `BEAN_DOSES`, so `BEANS`=1.
  - `BUSY`, `GRINDER`, `HEATER`, `PUMP`, `DONE`, `DROPPED` all 0.
- Reset mid-cycle aborts immediately: all outputs return to reset values, and the in-flight cup consumes nothing further.

## Timing
- Let edge k be the clock edge that samples an accepted request. With G/H/P for the three cycle parameters:
  - GRIND is entered after edge k.
  - HEAT after k+G; POUR after k+G+H; FINISH after k+G+H+P; IDLE after k+G+H+P+1.
- With defaults, `DONE` is high in the cycle following edge k+12, and the next request can be accepted at edge k+13.
- `BEANS` and `WATER` update in the same cycle as their transitions.
- `DROPPED` is high in the cycle following the sampling edge.
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.

## Structure
- `vmcoffee_pkg`:
  - State enum typedef.
  - Default localparams for cycle counts and the water/bean capacities, shared with `vmcoffee` and its bench.
- Sub-module `vmcoffee_phase_timer`:
  - 4-bit loadable down-counter with `load`/`value`/`expired`.
  - One instance, reloaded on each state entry.

## Test plan
- Reset, then one `COFFEE` pulse:
  - `GRINDER` high for 3 cycles, then `HEATER` for 4, then `PUMP` for 5.
  - `DONE` pulses 12 cycles after the accepting edge.
  - `WATER` goes 30→28 and the bean count goes 8→7.
- A second `COFFEE` edge during HEAT: `DROPPED` pulses once, and the cycle completes with normal timing and a single decrement.
- Nine back-to-back cups: cup 9 is dropped, and `BEANS`=0 after cup 8. `REFILL_B` in IDLE restores `BEANS`=1, and the next request is accepted.
- Starting with `WATER`=30 and no refill:
  - Fifteen cups bring `WATER` to 0.
  - The 16th is dropped, with no underflow.
  - `REFILL_W` restores 30, and `REFILL_W` asserted during POUR is ignored.
- `rstn` low for 1 ns during POUR: `PUMP`=0 and `BUSY`=0 immediately. `WATER` stays at its pre-cup value, with no `DONE` pulse.
- Integration with `vmcoffee`: a coin payment of 5+5 produces `COFFEE` and a full brew, and `vmcoffee` `ERROR` tracks `WATER`/`BEANS` driven by this block.
